counter_sched: RTL and testbench
================================

# counter_sched

Two-requester round-robin scheduler that shares the 8-bit loadable counter (count/load select, load value, tristate output enable) between two clients. Each granted job is a fixed sequence:
- load a start value;
- count for a requested number of cycles;
- drive the counter onto its tristate bus for one cycle and return the result.

Between jobs the scheduler freezes the counter by reloading its shadowed value. It sits directly above the counter instance in the top level.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  2  per-client request, level; bit i = client i
- start_val0  in  8  client 0 start value; sampled at grant
- len0  in  8  client 0 count length in cycles; sampled at grant
- start_val1  in  8  client 1 start value
- len1  in  8  client 1 count length
- gnt  out  2  one-hot owner, high from LOAD through DRIVE
- done  out  2  one-cycle pulse to owner, in DRIVE
- result  out  8  job result; valid while done is high, held afterwards
- ctr_load_select  out  1  to counter: 1 = load, 0 = count
- ctr_load_in  out  8  to counter load value
- ctr_oe  out  1  to counter output enable
- ctr_bus  in  8  counter tristate output, read back
- err  out  1  sticky readback mismatch flag (see Configuration)

## Operation
States: IDLE, LOAD, COUNT, DRIVE.

- **IDLE**
  - Counter outputs: ctr_load_select=1, ctr_load_in=shadow, ctr_oe=0. The counter holds its value.
  - If any req bit is set, arbitrate and go to LOAD.
  - On the IDLE->LOAD edge, latch owner, start_val_owner and len_owner.
- **Arbitration**
  - If only one bit of req is set, that client wins.
  - If both are set, the client not served last wins.
  - The last-served pointer resets to 1, so client 0 wins the first tie.
- **LOAD** (1 cycle)
  - ctr_load_select=1, ctr_load_in=latched start.
  - At the closing edge: shadow <= start; remaining <= len.
  - Next state is COUNT if len != 0, else DRIVE.
- **COUNT** (exactly len cycles)
  - ctr_load_select=0.
  - Each edge: shadow <= shadow+1 (mod 256); remaining <= remaining-1.
  - Exit to DRIVE on the edge where remaining == 1.
- **DRIVE** (1 cycle)
  - ctr_load_select=1, ctr_load_in=shadow, ctr_oe=1.
  - done[owner]=1; result = shadow = (start+len) mod 256.
  - Next state is IDLE; the last-served pointer becomes owner.
- **Counter outputs** are decoded from state and registers only, never from inputs. ctr_oe is high only in DRIVE.
- **req during a job**: changes or deassertion after grant are ignored and the job always completes. A req still high in IDLE starts a new job.
- **len=255**: start+255 wraps modulo 256, with no overflow indication.

## Timing
- **Reset values**:
  - state IDLE, gnt=00, done=00, result=0, shadow=0, pointer=1, err=0;
  - ctr_load_select=1, ctr_load_in=0, ctr_oe=0.
  - The shadow matches the counter because both reset to 0 on the same rst_n.
- **Latency**:
  - req high in IDLE at cycle t gives gnt at t+1 (LOAD).
  - DRIVE and done occur at t+2+len.
  - IDLE is reached at t+3+len.
- **Job spacing**: back-to-back jobs have at least one IDLE cycle between DRIVE and the next LOAD.
- **Reset mid-job**: everything returns immediately to the reset values. ctr_oe drops asynchronously, no done is issued, and the job is lost.

## Configuration
- **COUNTER_SCHED_CHECK_EN defined**: in DRIVE, compare ctr_bus with shadow.
  - On mismatch, err is set at the closing edge and stays set until rst_n.
  - result still reports shadow.
- **Not defined**: err is tied to 0, no comparator is built, and ctr_bus is unused.

## Test plan
- **Single job**: reset, then req=01 with start_val0=0x10, len0=3. Expect gnt=01 for 5 cycles; done=01 on the 5th cycle with result=0x13 and ctr_oe=1; ctr_bus=0x13.
- **Zero length**: req=10 with start_val1=0xAA, len1=0. Expect LOAD then DRIVE; done=10 at t+2 with result=0xAA.
- **Wrap**: start_val0=0xFE, len0=5. Expect result=0x03.
- **Tie and round-robin**: req=11 held continuously with len0=len1=1. Expect grants in order client 0, client 1, client 0; one IDLE cycle between each DRIVE and the next LOAD.
- **Reset mid-job**: pulse rst_n low during COUNT of a len=10 job. Expect all outputs at reset values, no done, and a new job from start_val=0x20, len=1 returning 0x21.
- **Check**: with COUNTER_SCHED_CHECK_EN defined, force ctr_bus=0x00 during DRIVE of a job expecting 0x13. Expect err=1 from the next cycle, still 1 after later good jobs, and 0 after reset.

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched: two-client round-robin scheduler for a shared 8-bit
// loadable counter. Each job loads a start value, counts for len cycles,
// then drives the counter onto its tristate bus for one cycle.
// Optional readback checker: define COUNTER_SCHED_CHECK_EN to build the
// DRIVE-cycle comparator behind the sticky err flag.
module counter_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [7:0] start_val0,
  input  logic [7:0] len0,
  input  logic [7:0] start_val1,
  input  logic [7:0] len1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] result,
  output logic       ctr_load_select,
  output logic [7:0] ctr_load_in,
  output logic       ctr_oe,
  input  logic [7:0] ctr_bus,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DRIVE} state_t;

  state_t     state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       last_reg, last_next;
  logic [7:0] start_reg, start_next;
  logic [7:0] len_reg, len_next;
  logic [7:0] shadow_reg, shadow_next;
  logic [7:0] remaining_reg, remaining_next;
  logic [7:0] result_reg, result_next;
  logic       winner;

  // State and job registers; everything returns to idle on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      start_reg     <= 8'd0;
      len_reg       <= 8'd0;
      shadow_reg    <= 8'd0;
      remaining_reg <= 8'd0;
      result_reg    <= 8'd0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      start_reg     <= start_next;
      len_reg       <= len_next;
      shadow_reg    <= shadow_next;
      remaining_reg <= remaining_next;
      result_reg    <= result_next;
    end
  end

  // Tie goes to the client not served last; otherwise the lone requester.
  assign winner = (req == 2'b11) ? ~last_reg : req[1];

  // Next-state logic: arbitration, job sequencing and shadow tracking.
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    start_next     = start_reg;
    len_next       = len_reg;
    shadow_next    = shadow_reg;
    remaining_next = remaining_reg;
    result_next    = result_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          owner_next = winner;
          start_next = winner ? start_val1 : start_val0;
          len_next   = winner ? len1 : len0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        shadow_next    = start_reg;
        remaining_next = len_reg;
        state_next     = (len_reg != 8'd0) ? COUNT : DRIVE;
      end
      COUNT: begin
        shadow_next    = shadow_reg + 8'd1;
        remaining_next = remaining_reg - 8'd1;
        if (remaining_reg == 8'd1) state_next = DRIVE;
      end
      DRIVE: begin
        result_next = shadow_reg;
        last_next   = owner_reg;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded purely from state and registers; idle reloads the
  // shadow so the counter stays frozen between jobs.
  always_comb begin
    gnt             = 2'b00;
    done            = 2'b00;
    result          = result_reg;
    ctr_load_select = 1'b1;
    ctr_load_in     = shadow_reg;
    ctr_oe          = 1'b0;
    case (state_reg)
      LOAD: begin
        gnt         = owner_reg ? 2'b10 : 2'b01;
        ctr_load_in = start_reg;
      end
      COUNT: begin
        gnt             = owner_reg ? 2'b10 : 2'b01;
        ctr_load_select = 1'b0;
      end
      DRIVE: begin
        gnt    = owner_reg ? 2'b10 : 2'b01;
        done   = owner_reg ? 2'b10 : 2'b01;
        result = shadow_reg;
        ctr_oe = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef COUNTER_SCHED_CHECK_EN
  logic err_reg;

  // Sticky flag: the bus readback disagreed with the shadow during DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_reg <= 1'b0;
    else if (state_reg == DRIVE && ctr_bus != shadow_reg) err_reg <= 1'b1;
  end

  assign err = err_reg;
`else
  logic unused_ctr_bus;
  assign unused_ctr_bus = ^ctr_bus;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sched.sv
// Testbench for counter_sched: job-level reference model plus a behavioural
// counter hanging off the ctr_* pins.
module tb_counter_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] start_val0, len0, start_val1, len1;
  logic [1:0] gnt, done;
  logic [7:0] result;
  logic       ctr_load_select;
  logic [7:0] ctr_load_in;
  logic       ctr_oe;
  wire  [7:0] ctr_bus;
  logic       err;

  logic [7:0] cnt;
  logic       bus_corrupt = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         last_srv = 1;
  logic       exp_err = 1'b0;
  logic [7:0] last_result = 8'd0;

  counter_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .start_val0(start_val0), .len0(len0),
    .start_val1(start_val1), .len1(len1),
    .gnt(gnt), .done(done), .result(result),
    .ctr_load_select(ctr_load_select), .ctr_load_in(ctr_load_in),
    .ctr_oe(ctr_oe), .ctr_bus(ctr_bus), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit loadable counter with tristate output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 8'd0;
    else if (ctr_load_select) cnt <= ctr_load_in;
    else cnt <= cnt + 8'd1;
  end
  assign ctr_bus = ctr_oe ? (bus_corrupt ? 8'h00 : cnt) : 8'hzz;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, gnt, 2'b00);
    chk({tag, "_done"}, done, 2'b00);
    chk({tag, "_result"}, result, 8'd0);
    chk({tag, "_sel"}, ctr_load_select, 1'b1);
    chk({tag, "_ldin"}, ctr_load_in, 8'd0);
    chk({tag, "_oe"}, ctr_oe, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  // One complete job, entered from an IDLE cycle; checks every cycle of it.
  task automatic run_job(input logic [1:0] r, input logic [7:0] s0, input logic [7:0] l0,
                         input logic [7:0] s1, input logic [7:0] l1,
                         input bit hold, input bit corrupt);
    int w, s, l, exp_res;
    req = r; start_val0 = s0; len0 = l0; start_val1 = s1; len1 = l1;
    if (r == 2'b11) w = (last_srv == 1) ? 0 : 1;
    else w = r[1] ? 1 : 0;
    s = w ? int'(s1) : int'(s0);
    l = w ? int'(l1) : int'(l0);
    exp_res = (s + l) % 256;
    tick;  // LOAD
    chk("load_gnt", gnt, 32'(1 << w));
    chk("load_sel", ctr_load_select, 1'b1);
    chk("load_ldin", ctr_load_in, s);
    chk("load_done", done, 2'b00);
    if (!hold) begin
      req = 2'b00;
      start_val0 = 8'($urandom); len0 = 8'($urandom);
      start_val1 = 8'($urandom); len1 = 8'($urandom);
    end
    for (int k = 0; k < l; k++) begin
      tick;  // COUNT
      chk("count_gnt", gnt, 32'(1 << w));
      chk("count_sel", ctr_load_select, 1'b0);
      chk("count_oe", ctr_oe, 1'b0);
      chk("count_done", done, 2'b00);
    end
    bus_corrupt = corrupt;
    tick;  // DRIVE
    chk("drive_gnt", gnt, 32'(1 << w));
    chk("drive_done", done, 32'(1 << w));
    chk("drive_result", result, exp_res);
    chk("drive_oe", ctr_oe, 1'b1);
    chk("drive_ldin", ctr_load_in, exp_res);
    if (!corrupt) chk("drive_bus", ctr_bus, exp_res);
    tick;  // IDLE
    bus_corrupt = 1'b0;
    if (corrupt) exp_err = 1'b1;
    chk("idle_gnt", gnt, 2'b00);
    chk("idle_done", done, 2'b00);
    chk("idle_oe", ctr_oe, 1'b0);
    chk("idle_result", result, exp_res);
    chk("idle_err", err, exp_err);
    last_srv = w;
    last_result = 8'(exp_res);
    $display("[TB] job client=%0d start=%0h len=%0d result=%0h", w, s, l, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00;
    start_val0 = 8'd0; len0 = 8'd0; start_val1 = 8'd0; len1 = 8'd0;
    #1;
    chk_reset_vals("reset");
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk_reset_vals("post_reset");

    // Directed jobs from the test plan.
    run_job(2'b01, 8'h10, 8'd3, 8'h00, 8'd0, 1'b0, 1'b0);
    run_job(2'b10, 8'h00, 8'd0, 8'hAA, 8'd0, 1'b0, 1'b0);
    run_job(2'b01, 8'hFE, 8'd5, 8'h00, 8'd0, 1'b0, 1'b0);
    run_job(2'b10, 8'h00, 8'd0, 8'h37, 8'd255, 1'b0, 1'b0);
    tick;

    // Reset the pointer, then a held tie must alternate 0,1,0.
    rst_n = 1'b0; last_srv = 1; last_result = 8'd0;
    tick;
    rst_n = 1'b1;
    tick;
    run_job(2'b11, 8'h01, 8'd1, 8'h02, 8'd1, 1'b1, 1'b0);
    run_job(2'b11, 8'h01, 8'd1, 8'h02, 8'd1, 1'b1, 1'b0);
    run_job(2'b11, 8'h01, 8'd1, 8'h02, 8'd1, 1'b0, 1'b0);

    // Reset during COUNT of a len=10 job: job lost, outputs back to reset.
    tick;
    req = 2'b01; start_val0 = 8'h40; len0 = 8'd10;
    tick;
    chk("mid_gnt", gnt, 2'b01);
    req = 2'b00;
    tick; tick; tick;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    exp_err = 1'b0; last_srv = 1;
    tick;
    chk_reset_vals("mid_hold");
    rst_n = 1'b1;
    tick;
    chk_reset_vals("mid_release");
    run_job(2'b01, 8'h20, 8'd1, 8'h00, 8'd0, 1'b0, 1'b0);

`ifdef COUNTER_SCHED_CHECK_EN
    // Corrupted readback sets err; it stays set until rst_n.
    run_job(2'b01, 8'h10, 8'd3, 8'h00, 8'd0, 1'b0, 1'b1);
    run_job(2'b10, 8'h00, 8'd0, 8'h05, 8'd2, 1'b0, 1'b0);
    rst_n = 1'b0; last_srv = 1; exp_err = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    chk("check_err_cleared", err, 1'b0);
`endif

    // Randomised jobs against the job-level model.
    for (int i = 0; i < 16; i++) begin
      run_job(2'($urandom_range(1, 3)),
              8'($urandom), 8'($urandom_range(0, 6)),
              8'($urandom), 8'($urandom_range(0, 6)),
              1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        tick;
        chk("gap_gnt", gnt, 2'b00);
        chk("gap_result", result, last_result);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
